updn_mod_counter: RTL and testbench
===================================

# updn_mod_counter

Parametrised up/down counter with a runtime modulus and wrap or saturate handling. It generalises the fixed 4-bit up-counter to WIDTH bits and adds enable, direction, synchronous load, terminal-count pulse and a sticky overflow flag. Timer, prescaler and event-count logic instantiate it wherever a programmable-range count is needed.

## Interface
- WIDTH, 8: counter width in bits, must be at least 2.
- clk  in  1  sole clock; all state updates on its rising edge.
- res  in  1  asynchronous, active-low reset; asserting it clears all state immediately, deassertion is synchronous to clk by the system.
- en  in  1  count enable.
- up  in  1  direction; 1 counts up, 0 counts down.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- limit  in  WIDTH  upper bound; count range is 0..limit inclusive.
- sat  in  1  boundary mode; 0 wraps, 1 saturates.
- clr_ovf  in  1  clears the sticky overflow flag.
- count  out  WIDTH  registered counter value.
- tc  out  1  registered one-cycle terminal-count pulse.
- ovf  out  1  registered sticky boundary flag.
- zero  out  1  combinational (count == 0).

## Operation
- Reset (res=0): count=0, tc=0, ovf=0; zero=1 as a consequence.
- Per-edge priority: load, then en, then hold.
- load=1: count <= min(load_val, limit); tc <= 0; ovf unaffected (except by clr_ovf); en and up are ignored.
- en=1, up=1, count < limit: count <= count+1.
- en=1, up=1, count >= limit is an up-boundary event.
  - sat=0: count <= 0.
  - sat=1: count <= limit. This also clamps a count left above a lowered limit.
- en=1, up=0, count > limit is treated as sat-independent: count <= limit. This is not a boundary event.
- en=1, up=0, 0 < count <= limit: count <= count-1.
- en=1, up=0, count == 0 is a down-boundary event.
  - sat=0: count <= limit.
  - sat=1: count <= 0.
- Any boundary event sets tc <= 1 for exactly the next cycle; otherwise tc <= 0.
- ovf <= 1 on any boundary event; else ovf <= 0 if clr_ovf=1; else ovf holds. Set wins over a simultaneous clear.
- limit=0: every enabled edge is a boundary event. count stays 0, and tc stays high while en=1.
- All arithmetic is WIDTH bits unsigned. No internal carry wider than WIDTH is exposed. limit = 2^WIDTH-1 gives full natural wrap.
- limit, sat and up are sampled only at the clock edge. Changing them mid-count takes effect on the next edge with no other side effects.

## Timing
- Latency: one clk edge from en/load/clr_ovf to updated count/tc/ovf.
- tc asserts in the cycle after the edge where the boundary was reached. It is high for one cycle per event, or continuously while events repeat every cycle.
- zero follows count combinationally, with no extra cycle.
- Reset assertion mid-count forces all outputs to reset values without waiting for clk. The first count after release happens on the first rising edge with en=1.
- No handshake: en may be held high indefinitely, one step per cycle.

## Test plan
- Reset: hold res=0 for 3 cycles with en=1 -> count=0, tc=0, ovf=0, zero=1. Assert res mid-count at count=5 -> count=0 immediately, before the next edge.
- Up wrap: WIDTH=8, limit=9, sat=0, up=1, en=1 from 0 -> count 0..9, then 0. tc is high for one cycle after the 9->0 edge, and ovf=1.
- Down saturate: limit=9, sat=1, up=0, load_val=2 with load, then en=1 -> count 2,1,0,0,0. tc is high each cycle once count held at 0. ovf=1. clr_ovf together with an event leaves ovf=1. clr_ovf with en=0 gives ovf=0.
- Load priority/clamp: load=1, en=1, load_val=200, limit=50 -> count=50, tc=0. Then load=1, load_val=7 -> count=7.
- Limit lowered: count=40, set limit=10, up=1, sat=1 -> count=10 with tc pulse. Repeat with sat=0 -> count=0. With up=0 -> count=10, no tc.
- Full range: limit=255, up=1 from 254 -> 255, 0; tc after the wrap. limit=0, en=1 -> count stays 0 and tc stays 1.

Source files
------------

// File: rtl/updn_mod_counter.sv
// ----------------------------------------------------------------------------
// updn_mod_counter
//   WIDTH-bit up/down counter with a runtime modulus (range 0..limit),
//   wrap-or-saturate boundary handling, synchronous load with clamping,
//   a registered one-cycle terminal-count pulse and a sticky overflow flag.
//   Reset is asynchronous and active-low on res.
// ----------------------------------------------------------------------------
module updn_mod_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  // Decoded conditions on the current count against the live limit.
  logic             at_zero;
  logic             below_limit;
  logic             above_limit;
  logic             up_event;
  logic             down_event;
  logic             boundary_event;
  logic [WIDTH-1:0] load_clamped;

  // Classify the current count and detect boundary events for this edge.
  always_comb begin
    at_zero        = (count_q == ZERO);
    below_limit    = (count_q < limit);
    above_limit    = (count_q > limit);
    // A count left above a lowered limit is a boundary when counting up
    // (it is caught by count >= limit) but only a clamp when counting down.
    up_event       = en && up && !below_limit;
    down_event     = en && !up && at_zero;
    // Load has priority over counting, so a loading edge is never an event.
    boundary_event = !load && (up_event || down_event);
    load_clamped   = (load_val > limit) ? limit : load_val;
  end

  // Next-state selection: load, then enabled count step, then hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    count_d = count_q;
    if (load) begin
      count_d = load_clamped;
    end else if (en) begin
      if (up) begin
        if (below_limit) begin
          count_d = count_q + ONE;
        end else begin
          count_d = sat ? limit : ZERO;
        end
      end else begin
        if (above_limit) begin
          count_d = limit;
        end else if (!at_zero) begin
          count_d = count_q - ONE;
        end else begin
          count_d = sat ? ZERO : limit;
        end
      end
    end
  end

  // Terminal-count pulse and sticky overflow; a set beats a simultaneous clear.
  always_comb begin
    tc_d  = boundary_event;
    ovf_d = ovf_q;
    if (boundary_event) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before this edge, independent of statement order.
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign zero  = (count_q == ZERO);

endmodule

// File: tb/tb_updn_mod_counter.sv
// ----------------------------------------------------------------------------
// tb_updn_mod_counter
//   Directed scenarios followed by randomized stimulus, all checked against
//   a behavioural model that tracks the counter as a plain integer.
// ----------------------------------------------------------------------------
module tb_updn_mod_counter;

  localparam int WIDTH = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             res;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic             sat;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             zero;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state.
  int m_count;
  int m_tc;
  int m_ovf;

  updn_mod_counter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .res      (res),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .sat      (sat),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Counter behaviour as integer arithmetic over the range 0..limit.
  task automatic model_edge();
    int lim;
    int evt;
    lim = int'(limit);
    evt = 0;
    if (!res) begin
      m_count = 0; m_tc = 0; m_ovf = 0;
      return;
    end
    if (load) begin
      m_count = (int'(load_val) < lim) ? int'(load_val) : lim;
    end else if (en) begin
      if (up) begin
        if (m_count < lim) m_count = m_count + 1;
        else begin evt = 1; m_count = sat ? lim : 0; end
      end else begin
        if (m_count > lim)     m_count = lim;
        else if (m_count > 0)  m_count = m_count - 1;
        else begin evt = 1; m_count = sat ? 0 : lim; end
      end
    end
    m_tc = evt;
    if (evt == 1)      m_ovf = 1;
    else if (clr_ovf)  m_ovf = 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(m_count));
    check({tag, ".tc"},    32'(tc),    32'(m_tc));
    check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    check({tag, ".zero"},  32'(zero),  32'(m_count == 0));
  endtask

  // One clock edge: advance the model, then sample 1 ns after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    en = 0; up = 1; load = 0; load_val = '0; sat = 0; clr_ovf = 0;
  endtask

  task automatic do_load(input int v, input int lim);
    idle_inputs();
    load = 1; load_val = WIDTH'(v); limit = WIDTH'(lim);
    step("load");
    load = 0;
  endtask

  initial begin
    idle_inputs();
    limit = 8'd9;
    res   = 1'b0;
    m_count = 0; m_tc = 0; m_ovf = 0;

    // Reset held with en=1 for 3 cycles.
    en = 1;
    repeat (3) step("reset");
    check("reset_zero", 32'(zero), 32'd1);
    @(negedge clk);
    res = 1'b1;

    // Count up to 5, then assert reset between edges.
    limit = 8'd9; up = 1; en = 1;
    repeat (5) step("pre_reset");
    check("pre_reset_count", 32'(count), 32'd5);
    #2;
    res = 1'b0;
    m_count = 0; m_tc = 0; m_ovf = 0;
    #1;
    compare_all("async_reset");
    check("async_reset_count", 32'(count), 32'd0);
    @(negedge clk);
    res = 1'b1;

    // Up wrap over limit=9.
    idle_inputs();
    en = 1; up = 1; limit = 8'd9;
    for (int i = 1; i <= 9; i++) step("up_wrap");
    check("up_wrap_top", 32'(count), 32'd9);
    step("up_wrap");
    check("up_wrap_cnt", 32'(count), 32'd0);
    check("up_wrap_tc", 32'(tc), 32'd1);
    check("up_wrap_ovf", 32'(ovf), 32'd1);
    step("up_wrap_after");
    check("up_wrap_tc_drop", 32'(tc), 32'd0);

    // Down saturate from 2.
    do_load(2, 9);
    en = 1; up = 0; sat = 1;
    for (int i = 0; i < 4; i++) step("down_sat");
    check("down_sat_cnt", 32'(count), 32'd0);
    check("down_sat_tc", 32'(tc), 32'd1);
    clr_ovf = 1;
    step("clr_with_evt");
    check("clr_with_evt_ovf", 32'(ovf), 32'd1);
    en = 0;
    step("clr_idle");
    check("clr_idle_ovf", 32'(ovf), 32'd0);
    clr_ovf = 0;

    // Load priority and clamp.
    idle_inputs();
    en = 1; load = 1; load_val = 8'd200; limit = 8'd50;
    step("load_clamp");
    check("load_clamp_cnt", 32'(count), 32'd50);
    check("load_clamp_tc", 32'(tc), 32'd0);
    load_val = 8'd7;
    step("load_7");
    check("load_7_cnt", 32'(count), 32'd7);

    // Limit lowered below the current count.
    do_load(40, 255);
    en = 1; up = 1; sat = 1; limit = 8'd10;
    step("lower_sat");
    check("lower_sat_cnt", 32'(count), 32'd10);
    check("lower_sat_tc", 32'(tc), 32'd1);
    do_load(40, 255);
    en = 1; up = 1; sat = 0; limit = 8'd10;
    step("lower_wrap");
    check("lower_wrap_cnt", 32'(count), 32'd0);
    do_load(40, 255);
    en = 1; up = 0; limit = 8'd10;
    step("lower_down");
    check("lower_down_cnt", 32'(count), 32'd10);
    check("lower_down_tc", 32'(tc), 32'd0);

    // Full range wrap and limit=0.
    do_load(254, 255);
    en = 1; up = 1; sat = 0; limit = 8'd255;
    step("full");
    check("full_255", 32'(count), 32'd255);
    step("full");
    check("full_wrap", 32'(count), 32'd0);
    check("full_tc", 32'(tc), 32'd1);
    limit = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step("lim0");
      check("lim0_tc", 32'(tc), 32'd1);
    end

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(3) != 0);
      up      = $urandom_range(1);
      load    = ($urandom_range(7) == 0);
      load_val = WIDTH'($urandom_range(MAXV));
      sat     = $urandom_range(1);
      clr_ovf = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) begin
        case ($urandom_range(3))
          0: limit = WIDTH'($urandom_range(15));
          1: limit = WIDTH'(MAXV);
          2: limit = '0;
          default: limit = WIDTH'($urandom_range(MAXV));
        endcase
      end
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
